// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Purpose  : Program-counter and sequencing register stage for the multi-cycle
//            LEGv8 datapath. Holds the architectural PC, instruction register,
//            NZCV status register and control state. It applies the PC function
//            selected by the control-unit decoders.
//
// Ports    : clock        in   rising-edge clock
//            reset_n      in   asynchronous active-low reset
//            PC_FS        in   00 hold, 01 PC+4, 10 load PC_in, 11 PC-relative
//            PC_in        in   absolute jump target
//            k_imm        in   raw branch immediate, instruction bits [25:0]
//            k_sel        in   0: 26-bit offset k_imm[25:0]; 1: 19-bit k_imm[23:5]
//            NS           in   next control state
//            status_load  in   capture status_in
//            status_in    in   NZCV from ALU
//            IR_load      in   capture instr_in
//            instr_in     in   instruction word from memory
//            PC_out       out  current PC
//            PC_plus4     out  PC_out + 4 (combinational, BL link value)
//            IR           out  instruction register
//            status       out  NZCV register
//            state        out  current control state
//            align_fault  out  sticky misaligned-load flag
//
// Config   : PC_ALIGN_CHECK_EN
//            defined   - a misaligned absolute load leaves PC unchanged and sets
//                        align_fault, which stays set until reset.
//            undefined - the low two bits of PC_in are cleared on load, and
//                        align_fault is tied low.
//
// Revision : 1.0  initial release
// ============================================================================
module pc_unit #(
    parameter int                 WIDTH        = 64,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       PC_FS,
    input  logic [WIDTH-1:0] PC_in,
    input  logic [25:0]      k_imm,
    input  logic             k_sel,
    input  logic [3:0]       NS,
    input  logic             status_load,
    input  logic [3:0]       status_in,
    input  logic             IR_load,
    input  logic [31:0]      instr_in,
    output logic [WIDTH-1:0] PC_out,
    output logic [WIDTH-1:0] PC_plus4,
    output logic [31:0]      IR,
    output logic [3:0]       status,
    output logic [3:0]       state,
    output logic             align_fault
);

    logic [WIDTH-1:0] pc_q,     pc_d;
    logic [31:0]      ir_q,     ir_d;
    logic [3:0]       status_q, status_d;
    logic [3:0]       state_q,  state_d;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_offset;
    logic [WIDTH-1:0] w_jump;

    // Word offset is sign-extended to full width first, so the <<2 keeps the
    // sign and the add wraps modulo 2^WIDTH. Relative to PC_out, not PC+4.
    assign w_offset   = k_sel ? {{(WIDTH-19){k_imm[23]}}, k_imm[23:5]}
                              : {{(WIDTH-26){k_imm[25]}}, k_imm[25:0]};
    assign w_jump     = pc_q + (w_offset << 2);
    assign w_pc_plus4 = pc_q + WIDTH'(4);

`ifdef PC_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q;
        case (PC_FS)
            2'b01:   pc_d = w_pc_plus4;
            2'b10: begin
                if (PC_in[1:0] != 2'b00) begin
                    fault_d = 1'b1;
                end else begin
                    pc_d = PC_in;
                end
            end
            2'b11:   pc_d = w_jump;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign align_fault = fault_q;
`else
    logic [WIDTH-1:0] w_pc_in_aligned;

    assign w_pc_in_aligned = PC_in & ~{{(WIDTH-2){1'b0}}, 2'b11};

    always_comb begin
        pc_d = pc_q;
        case (PC_FS)
            2'b01:   pc_d = w_pc_plus4;
            2'b10:   pc_d = w_pc_in_aligned;
            2'b11:   pc_d = w_jump;
            default: pc_d = pc_q;
        endcase
    end

    assign align_fault = 1'b0;
`endif

    // state follows NS unconditionally; IR and status are independent loads.
    always_comb begin
        state_d  = NS;
        ir_d     = IR_load     ? instr_in  : ir_q;
        status_d = status_load ? status_in : status_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= RESET_VECTOR;
            ir_q     <= 32'h0;
            status_q <= 4'h0;
            state_q  <= 4'h0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            status_q <= status_d;
            state_q  <= state_d;
        end
    end

    assign PC_out   = pc_q;
    assign PC_plus4 = w_pc_plus4;
    assign IR       = ir_q;
    assign status   = status_q;
    assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Purpose  : Self-checking bench for pc_unit: directed vector table, reset and
//            alignment sequences, then random stimulus against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_unit;

    localparam logic [63:0] RV = 64'h0000_0000_0000_1000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  PC_FS;
    logic [63:0] PC_in;
    logic [25:0] k_imm;
    logic        k_sel;
    logic [3:0]  NS;
    logic        status_load;
    logic [3:0]  status_in;
    logic        IR_load;
    logic [31:0] instr_in;
    logic [63:0] PC_out;
    logic [63:0] PC_plus4;
    logic [31:0] IR;
    logic [3:0]  status;
    logic [3:0]  state;
    logic        align_fault;

    pc_unit #(.WIDTH(64), .RESET_VECTOR(RV)) dut (
        .clock(clock), .reset_n(reset_n), .PC_FS(PC_FS), .PC_in(PC_in),
        .k_imm(k_imm), .k_sel(k_sel), .NS(NS), .status_load(status_load),
        .status_in(status_in), .IR_load(IR_load), .instr_in(instr_in),
        .PC_out(PC_out), .PC_plus4(PC_plus4), .IR(IR), .status(status),
        .state(state), .align_fault(align_fault)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  fs;
        logic [63:0] pc_in;
        logic [25:0] k;
        logic        ks;
        logic [3:0]  ns;
        logic        sl;
        logic [3:0]  si;
        logic        il;
        logic [31:0] ii;
        logic [63:0] e_pc;
        logic [31:0] e_ir;
        logic [3:0]  e_st;
        logic [3:0]  e_state;
    } vec_t;

    vec_t vecs[13];

    task automatic drive(input logic [1:0] fs, input logic [63:0] pin, input logic [25:0] k,
                         input logic ks, input logic [3:0] ns, input logic sl,
                         input logic [3:0] si, input logic il, input logic [31:0] ii);
        PC_FS = fs; PC_in = pin; k_imm = k; k_sel = ks; NS = ns;
        status_load = sl; status_in = si; IR_load = il; instr_in = ii;
    endtask

    // Applies inputs at the falling edge and samples 1 time unit after the
    // following rising edge.
    task automatic step(input logic [1:0] fs, input logic [63:0] pin, input logic [25:0] k,
                        input logic ks, input logic [3:0] ns, input logic sl,
                        input logic [3:0] si, input logic il, input logic [31:0] ii);
        @(negedge clock);
        drive(fs, pin, k, ks, ns, sl, si, il, ii);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        drive(2'b00, 64'h0, 26'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Reference model state.
    logic [63:0] m_pc;
    logic [31:0] m_ir;
    logic [3:0]  m_st, m_state;
    logic        m_fault;
    longint      off;
    logic [1:0]  r_fs;
    logic [63:0] r_pin;
    logic [25:0] r_k;
    logic        r_ks, r_sl, r_il;
    logic [3:0]  r_ns, r_si;
    logic [31:0] r_ii;

    initial begin
        vecs[0]  = '{2'b10, 64'h0,                  26'h0,       1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                     64'h0,                  32'h0,        4'h0, 4'h0};
        vecs[1]  = '{2'b01, 64'h0,                  26'h0,       1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                     64'h4,                  32'h0,        4'h0, 4'h0};
        vecs[2]  = '{2'b01, 64'h0,                  26'h0,       1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                     64'h8,                  32'h0,        4'h0, 4'h0};
        vecs[3]  = '{2'b01, 64'h0,                  26'h0,       1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                     64'hC,                  32'h0,        4'h0, 4'h0};
        vecs[4]  = '{2'b10, 64'h100,                26'h0,       1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 32'hDEADBEEF,
                     64'h100,                32'hDEADBEEF, 4'h0, 4'h0};
        vecs[5]  = '{2'b11, 64'h0,                  26'h3FFFFFE, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                     64'hF8,                 32'hDEADBEEF, 4'h0, 4'h0};
        vecs[6]  = '{2'b00, 64'h0,                  26'h0,       1'b0, 4'h1, 1'b1, 4'h4, 1'b0, 32'h0,
                     64'hF8,                 32'hDEADBEEF, 4'h4, 4'h1};
        vecs[7]  = '{2'b11, 64'h0,                  26'h0000060, 1'b1, 4'h2, 1'b0, 4'h0, 1'b0, 32'h0,
                     64'h104,                32'hDEADBEEF, 4'h4, 4'h2};
        vecs[8]  = '{2'b10, 64'hFFFFFFFFFFFFFFFC,   26'h0,       1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                     64'hFFFFFFFFFFFFFFFC,   32'hDEADBEEF, 4'h4, 4'h0};
        vecs[9]  = '{2'b01, 64'h0,                  26'h0,       1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                     64'h0,                  32'hDEADBEEF, 4'h4, 4'h0};
        vecs[10] = '{2'b11, 64'h0,                  26'h0FFFFE0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                     64'hFFFFFFFFFFFFFFFC,   32'hDEADBEEF, 4'h4, 4'h0};
        vecs[11] = '{2'b00, 64'h0,                  26'h0,       1'b0, 4'hF, 1'b1, 4'hA, 1'b1, 32'h12345678,
                     64'hFFFFFFFFFFFFFFFC,   32'h12345678, 4'hA, 4'hF};
        vecs[12] = '{2'b11, 64'h0,                  26'h0000001, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                     64'h0,                  32'h12345678, 4'hA, 4'h0};

        reset_n = 1'b0;
        drive(2'b00, 64'h0, 26'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
        #12;
        chk("reset_pc",     PC_out,      RV);
        chk("reset_plus4",  PC_plus4,    RV + 64'd4);
        chk("reset_fault",  {63'h0, align_fault}, 64'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].fs, vecs[i].pc_in, vecs[i].k, vecs[i].ks, vecs[i].ns,
                 vecs[i].sl, vecs[i].si, vecs[i].il, vecs[i].ii);
            chk($sformatf("vec%0d_pc", i),     PC_out,          vecs[i].e_pc);
            chk($sformatf("vec%0d_plus4", i),  PC_plus4,        vecs[i].e_pc + 64'd4);
            chk($sformatf("vec%0d_ir", i),     {32'h0, IR},     {32'h0, vecs[i].e_ir});
            chk($sformatf("vec%0d_status", i), {60'h0, status}, {60'h0, vecs[i].e_st});
            chk($sformatf("vec%0d_state", i),  {60'h0, state},  {60'h0, vecs[i].e_state});
        end

        // Asynchronous reset in the middle of a cycle, with PC=0x40.
        step(2'b10, 64'h40, 26'h0, 1'b0, 4'h7, 1'b1, 4'h9, 1'b1, 32'hCAFEF00D);
        chk("pre_reset_pc", PC_out, 64'h40);
        @(negedge clock);
        drive(2'b01, 64'h0, 26'h0, 1'b0, 4'h3, 1'b1, 4'h5, 1'b1, 32'h11111111);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_pc",     PC_out,          RV);
        chk("async_reset_ir",     {32'h0, IR},     64'h0);
        chk("async_reset_status", {60'h0, status}, 64'h0);
        chk("async_reset_state",  {60'h0, state},  64'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Misaligned absolute load.
        step(2'b10, 64'h100, 26'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
        step(2'b10, 64'h103, 26'h0, 1'b0, 4'h6, 1'b0, 4'h0, 1'b0, 32'h0);
        chk("align_state", {60'h0, state}, 64'h6);
`ifdef PC_ALIGN_CHECK_EN
        chk("align_pc_hold", PC_out, 64'h100);
        chk("align_fault_set", {63'h0, align_fault}, 64'h1);
        step(2'b01, 64'h0, 26'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
        chk("align_fault_sticky", {63'h0, align_fault}, 64'h1);
        chk("align_after_pc", PC_out, 64'h104);
`else
        chk("align_pc_forced", PC_out, 64'h100);
        chk("align_fault_zero", {63'h0, align_fault}, 64'h0);
`endif
        do_reset();
        chk("align_fault_cleared", {63'h0, align_fault}, 64'h0);

        // Random stimulus against the reference model.
        m_pc = RV; m_ir = 32'h0; m_st = 4'h0; m_state = 4'h0; m_fault = 1'b0;
        for (int n = 0; n < 400; n++) begin
            r_fs  = 2'($urandom_range(0, 3));
            r_pin = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) r_pin[1:0] = 2'b00;
            r_k   = 26'($urandom);
            r_ks  = 1'($urandom);
            r_ns  = 4'($urandom);
            r_sl  = 1'($urandom);
            r_si  = 4'($urandom);
            r_il  = 1'($urandom);
            r_ii  = $urandom;
            step(r_fs, r_pin, r_k, r_ks, r_ns, r_sl, r_si, r_il, r_ii);

            case (r_fs)
                2'd1: m_pc = m_pc + 64'd4;
                2'd2: begin
`ifdef PC_ALIGN_CHECK_EN
                    if (r_pin % 4 != 0) m_fault = 1'b1;
                    else                m_pc = r_pin;
`else
                    m_pc = r_pin - (r_pin % 4);
`endif
                end
                2'd3: begin
                    if (!r_ks) begin
                        off = longint'(r_k);
                        if (off >= 64'sh2000000) off = off - 64'sh4000000;
                    end else begin
                        off = longint'(r_k / 32) % 524288;
                        if (off >= 262144) off = off - 524288;
                    end
                    m_pc = m_pc + 64'(off * 4);
                end
                default: ;
            endcase
            m_state = r_ns;
            if (r_sl) m_st = r_si;
            if (r_il) m_ir = r_ii;

            chk("rnd_pc",     PC_out,          m_pc);
            chk("rnd_plus4",  PC_plus4,        m_pc + 64'd4);
            chk("rnd_ir",     {32'h0, IR},     {32'h0, m_ir});
            chk("rnd_status", {60'h0, status}, {60'h0, m_st});
            chk("rnd_state",  {60'h0, state},  {60'h0, m_state});
            chk("rnd_fault",  {63'h0, align_fault}, {63'h0, m_fault});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
